button_cmd_ctrl: RTL and testbench

BUTTON_CMD_CTRL -- requirements
Module: button_cmd_ctrl

---
 rtl/button_pkg.sv | 19 +
 rtl/btn_press_fsm.sv | 92 +++++++++
 rtl/button_cmd_ctrl.sv | 123 ++++++++++++
 tb/tb_button_cmd_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and widths for the button command controller.
package button_pkg;

  // Per-button press FSM encoding.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_e;

  localparam int STATE_W    = 2;
  localparam int EVT_LONG_W = 1;

  // Width of a button index field; never narrower than one bit.
  function automatic int btn_idx_w(input int n_btn);
    return (n_btn < 2) ? 1 : $clog2(n_btn);
  endfunction

endpackage

// File: rtl/btn_press_fsm.sv
// One button: classifies presses as short/long and holds one pending event
// until the arbiter grants it.
module btn_press_fsm
  import button_pkg::*;
#(
  parameter int LONG_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       grant,
  output logic       pend,
  output logic       pend_long,
  output logic       drop,
  output btn_state_e state_dbg
);

  localparam int CNT_W = (LONG_CYCLES < 2) ? 1 : $clog2(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CYCLES - 1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             pend_long_q, pend_long_d;
  logic             evt, evt_long;

  // State, hold counter and pending event registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_long_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
    end
  end

  // Next state, counter, event generation and pending-slot update.
  // The counter stops at CNT_LAST because PRESSED leaves on that value.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    evt         = 1'b0;
    evt_long    = 1'b0;
    drop        = 1'b0;
    pend_d      = pend_q & ~grant;
    pend_long_d = pend_long_q;
    case (state_q)
      IDLE: begin
        if (btn) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (!btn) begin
          state_d = IDLE;
          evt     = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = LONG_HELD;
          evt      = 1'b1;
          evt_long = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A slot being granted this cycle is free for a new event; otherwise an
    // event arriving on a full slot is dropped and the older one kept.
    if (evt) begin
      if (pend_q && !grant) begin
        drop = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_long_d = evt_long;
      end
    end
  end

  assign pend      = pend_q;
  assign pend_long = pend_long_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/button_cmd_ctrl.sv
// Button command controller: per-button press FSMs feed a round-robin
// arbiter that pushes one command per cycle into a small FIFO.
//
// Handshake: cmd_valid is high while the FIFO holds a command, the head is
// presented on cmd_btn/cmd_long, and it is consumed on a rising edge where
// cmd_valid and cmd_ready are both high; cmd_ready is ignored when empty.
module button_cmd_ctrl
  import button_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int LONG_CYCLES = 50000000,
  parameter int FIFO_DEPTH  = 4,
  localparam int BTN_W      = btn_idx_w(N_BTN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         btn_in,
  input  logic                     cmd_ready,
  input  logic                     ovf_clr,
  output logic                     cmd_valid,
  output logic [BTN_W-1:0]         cmd_btn,
  output logic                     cmd_long,
  output logic                     ovf_flag,
  output logic [STATE_W*N_BTN-1:0] dbg_btn_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N_BTN-1:0] pend, pend_long, drop, grant_vec;
  logic             grant_found, can_push, push, pop, full;
  logic [BTN_W-1:0] rr_ptr, grant_idx, scan_idx;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [BTN_W-1:0] mem_btn  [FIFO_DEPTH];
  logic             mem_long [FIFO_DEPTH];

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_state_e st;
    btn_press_fsm #(.LONG_CYCLES(LONG_CYCLES)) u_fsm (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn_in[g]),
      .grant     (grant_vec[g]),
      .pend      (pend[g]),
      .pend_long (pend_long[g]),
      .drop      (drop[g]),
      .state_dbg (st)
    );
    assign dbg_btn_state[g*STATE_W +: STATE_W] = st;
  end

  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign cmd_valid = (fifo_count != '0);
  assign pop       = cmd_valid & cmd_ready;
  assign can_push  = !full || pop;
  assign push      = grant_found;
  assign cmd_btn   = mem_btn[rd_ptr];
  assign cmd_long  = mem_long[rd_ptr];

  // Round-robin search for the first pending button starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    grant_vec   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      scan_idx = BTN_W'((int'(rr_ptr) + i) % N_BTN);
      if (can_push && !grant_found && pend[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    if (grant_found) grant_vec[grant_idx] = 1'b1;
  end

  // Arbiter pointer: next search starts just after the last grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_found) begin
      rr_ptr <= (grant_idx == BTN_W'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Command FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_btn[i]  <= '0;
        mem_long[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_btn[wr_ptr]  <= grant_idx;
        mem_long[wr_ptr] <= pend_long[grant_idx];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_flag <= 1'b0;
    end else if (|drop) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_cmd_ctrl.sv
// Self-checking bench for button_cmd_ctrl with a command scoreboard.
module tb_button_cmd_ctrl;

  localparam int N_BTN       = 4;
  localparam int LONG_CYCLES = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int BTN_W       = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_BTN-1:0]   btn_in;
  logic               cmd_ready;
  logic               ovf_clr;
  logic               cmd_valid;
  logic [BTN_W-1:0]   cmd_btn;
  logic               cmd_long;
  logic               ovf_flag;
  logic [2*N_BTN-1:0] dbg_btn_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cmds   = 0;
  int base_cmds;
  logic [BTN_W:0] exp_q[$];
  logic [BTN_W:0] exp_cmd;

  button_cmd_ctrl #(
    .N_BTN       (N_BTN),
    .LONG_CYCLES (LONG_CYCLES),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_in        (btn_in),
    .cmd_ready     (cmd_ready),
    .ovf_clr       (ovf_clr),
    .cmd_valid     (cmd_valid),
    .cmd_btn       (cmd_btn),
    .cmd_long      (cmd_long),
    .ovf_flag      (ovf_flag),
    .dbg_btn_state (dbg_btn_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic expect_cmd(input int b, input logic lng);
    exp_q.push_back({BTN_W'(b), lng});
  endtask

  // Scoreboard: compare the head on every accepted command.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        check("cmd_spurious_q_size", exp_q.size(), 1);
      end else begin
        exp_cmd = exp_q.pop_front();
        check("cmd_head", {cmd_btn, cmd_long}, exp_cmd);
        n_cmds++;
      end
    end
  end

  initial begin
    reset     = 1'b1;
    btn_in    = '0;
    cmd_ready = 1'b0;
    ovf_clr   = 1'b0;
    tick(2);
    check("rst_valid", cmd_valid, 0);
    check("rst_btn", cmd_btn, 0);
    check("rst_long", cmd_long, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_state", dbg_btn_state, 0);
    reset = 1'b0;

    // Short press on button 2.
    cmd_ready = 1'b1;
    btn_in[2] = 1'b1;
    tick(3);
    check("s1_state_pressed", dbg_btn_state[5:4], 1);
    btn_in[2] = 1'b0;
    expect_cmd(2, 1'b0);
    tick(1);
    check("s1_valid_early", cmd_valid, 0);
    tick(1);
    check("s1_valid", cmd_valid, 1);
    check("s1_btn", cmd_btn, 2);
    check("s1_long", cmd_long, 0);
    tick(2);
    check("s1_single", cmd_valid, 0);

    // Long press on button 1, held 20 cycles.
    btn_in[1] = 1'b1;
    expect_cmd(1, 1'b1);
    tick(9);
    check("s2_valid_early", cmd_valid, 0);
    tick(1);
    check("s2_valid", cmd_valid, 1);
    check("s2_long", cmd_long, 1);
    tick(10);
    check("s2_state_long", dbg_btn_state[3:2], 2);
    btn_in[1] = 1'b0;
    tick(4);
    check("s2_no_release_cmd", cmd_valid, 0);
    check("s2_q_empty", exp_q.size(), 0);

    // Simultaneous release of all buttons.
    do_reset();
    btn_in = 4'hF;
    tick(2);
    btn_in = 4'h0;
    for (int i = 0; i < N_BTN; i++) expect_cmd(i, 1'b0);
    tick(1);
    for (int i = 0; i < N_BTN; i++) begin
      tick(1);
      check("s3_valid", cmd_valid, 1);
      check("s3_order", cmd_btn, i);
    end
    tick(1);
    check("s3_done", cmd_valid, 0);

    // Six short presses with the consumer stalled; drop coincides with a clear.
    cmd_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      btn_in[0] = 1'b1;
      tick(1);
      btn_in[0] = 1'b0;
      if (i == 5) ovf_clr = 1'b1;
      if (i < 5) expect_cmd(0, 1'b0);
      tick(1);
      ovf_clr = 1'b0;
    end
    tick(1);
    check("s4_ovf_set_wins", ovf_flag, 1);
    check("s4_full_count", dut.fifo_count, 4);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("s4_ovf_clr", ovf_flag, 0);
    base_cmds = n_cmds;
    cmd_ready = 1'b1;
    tick(1);
    check("s4_full_push_pop_count", dut.fifo_count, 4);
    tick(6);
    check("s4_drained", n_cmds - base_cmds, 5);
    check("s4_empty", cmd_valid, 0);
    check("s4_q_empty", exp_q.size(), 0);

    // Reset mid-press on button 3, then released without a new edge.
    btn_in[3] = 1'b1;
    tick(5);
    do_reset();
    tick(3);
    check("s5_no_cmd", cmd_valid, 0);
    btn_in[3] = 1'b0;
    expect_cmd(3, 1'b0);
    tick(4);
    check("s5_q_empty", exp_q.size(), 0);
    check("s5_idle", cmd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
